// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: buffers ALU commands in a FIFO and issues them one at a time to a multi-cycle ALU.
// Ports: cmd_valid/cmd_ready/cmd_mode/cmd_a/cmd_b take commands in; alu_valid/alu_mode/alu_in_A/alu_in_B
// start the ALU; alu_ready/alu_out bring its result back; rsp_valid/rsp_ready/rsp_data/rsp_mode/rsp_err
// return results in command order. Define ALU_TIMEOUT_EN to add a WAIT watchdog that aborts after TIMEOUT cycles.
module alu_cmd_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 63
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_mode,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  output logic        alu_valid,
  output logic [1:0]  alu_mode,
  output logic [31:0] alu_in_A,
  output logic [31:0] alu_in_B,
  input  logic        alu_ready,
  input  logic [63:0] alu_out,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_data,
  output logic [1:0]  rsp_mode,
  output logic        rsp_err
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;
  state_t state_q, state_d;
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [65:0] mem_q [DEPTH];
  logic [65:0] head;
  logic [1:0]  alu_mode_q, alu_mode_d, rsp_mode_q, rsp_mode_d;
  logic [31:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [63:0] rsp_data_q, rsp_data_d;
  logic        empty, full, push, pop, timeout;
  assign empty = wr_q == rd_q;
  assign full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign push = cmd_valid && !full;
  assign pop = state_q == IDLE && !empty;
  assign head = mem_q[rd_q[AW-1:0]];
  assign cmd_ready = !full;
  assign alu_valid = state_q == ISSUE;
  assign rsp_valid = state_q == HOLD;
  assign alu_mode = alu_mode_q;
  assign alu_in_A = alu_a_q;
  assign alu_in_B = alu_b_q;
  assign rsp_data = rsp_data_q;
  assign rsp_mode = rsp_mode_q;
`ifdef ALU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rsp_err_q, rsp_err_d;
  // count is zero outside WAIT, so it is already cleared on WAIT entry; abort on the TIMEOUT-th WAIT cycle
  assign cnt_d = state_q == WAIT ? cnt_q + CW'(1) : '0;
  assign timeout = state_q == WAIT && cnt_d == CW'(TIMEOUT);
  assign rsp_err_d = (state_q == WAIT && (alu_ready || timeout)) ? !alu_ready : rsp_err_q;
  assign rsp_err = rsp_err_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      rsp_err_q <= rsp_err_d;
    end
`else
  localparam int unused_timeout = TIMEOUT;
  assign timeout = 1'b0;
  assign rsp_err = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    alu_mode_d = alu_mode_q;
    alu_a_d = alu_a_q;
    alu_b_d = alu_b_q;
    rsp_data_d = rsp_data_q;
    rsp_mode_d = rsp_mode_q;
    wr_d = wr_q + {{AW{1'b0}}, push};
    rd_d = rd_q + {{AW{1'b0}}, pop};
    case (state_q)
      IDLE: if (!empty) begin
        state_d = ISSUE;
        {alu_mode_d, alu_a_d, alu_b_d} = head;
      end
      ISSUE: state_d = WAIT;
      WAIT: if (alu_ready || timeout) begin
        state_d = HOLD;
        rsp_data_d = alu_ready ? alu_out : '0;
        rsp_mode_d = alu_mode_q;
      end
      default: state_d = rsp_ready ? IDLE : HOLD;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      wr_q <= '0;
      rd_q <= '0;
      alu_mode_q <= '0;
      alu_a_q <= '0;
      alu_b_q <= '0;
      rsp_data_q <= '0;
      rsp_mode_q <= '0;
    end else begin
      state_q <= state_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      alu_mode_q <= alu_mode_d;
      alu_a_q <= alu_a_d;
      alu_b_q <= alu_b_d;
      rsp_data_q <= rsp_data_d;
      rsp_mode_q <= rsp_mode_d;
    end
  always_ff @(posedge clk)
    if (push) mem_q[wr_q[AW-1:0]] <= {cmd_mode, cmd_a, cmd_b};
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: random and directed stimulus against a transaction-level timing model of the sequencer.
module tb_alu_cmd_sequencer;
  localparam int DEPTH = 4;
  localparam int TO = 63;
  logic        clk, rst_n, cmd_valid, cmd_ready, alu_valid, alu_ready, rsp_valid, rsp_ready, rsp_err;
  logic [1:0]  cmd_mode, alu_mode, rsp_mode;
  logic [31:0] cmd_a, cmd_b, alu_in_A, alu_in_B;
  logic [63:0] alu_out, rsp_data;
  alu_cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .alu_valid(alu_valid), .alu_mode(alu_mode), .alu_in_A(alu_in_A),
    .alu_in_B(alu_in_B), .alu_ready(alu_ready), .alu_out(alu_out), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_mode(rsp_mode), .rsp_err(rsp_err)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  typedef struct {logic [1:0] m; logic [31:0] a, b; int av;} cmd_t;
  int vec = 0, errs = 0, ncmp = 0, nav = 0, force_lat = 0;
  bit spur_en = 0;
  logic [63:0] obs[$];
  logic [1:0]  obs_mode[$];
  logic        obs_err[$];
  function automatic logic [63:0] alu_f(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b);
    case (m)
      2'd0: return {32'b0, a} * {32'b0, b};
      2'd1: return b == 0 ? '1 : {a % b, a / b};
      2'd2: return {32'b0, a} << b[5:0];
      default: return ({32'b0, a} + {32'b0, b}) >> 1;
    endcase
  endfunction
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  // environment ALU: answers each start pulse after a latency, plus stray ready pulses when idle
  initial begin
    int ec, rdy_at;
    bit pend, lost;
    logic [63:0] res;
    ec = 0; pend = 0; lost = 0; res = 0;
    alu_ready = 0; alu_out = 0;
    forever begin
      @(posedge clk); #1;
      ec++;
      alu_ready = 0;
      alu_out = {$urandom, $urandom};
      if (!rst_n) begin
        pend = 0; lost = 0;
      end else begin
        if (pend && ec == rdy_at) begin
          alu_ready = 1; alu_out = res; pend = 0;
        end else if (!pend && !lost && !alu_valid && spur_en && $urandom_range(0, 7) == 0)
          alu_ready = 1;
        if (alu_valid) begin
          lost = force_lat < 0;
          pend = force_lat >= 0;
          rdy_at = ec + (force_lat > 0 ? force_lat : $urandom_range(1, 40));
          res = alu_f(alu_mode, alu_in_A, alu_in_B);
        end
      end
    end
  end
  // reference model: commands become issuable 2 cycles after acceptance and 2 cycles after the previous
  // response handshake; results appear the cycle after the ALU answers and stay until accepted
  cmd_t q[$];
  cmd_t cur;
  bit has_cur = 0, got = 0, e_err = 0;
  int t = 0, issue = 0, rdy_t = 0, free_at = 0;
  logic [63:0] e_data = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_alu_valid", alu_valid, 0);
      chk("rst_alu_mode", alu_mode, 0);
      chk("rst_alu_in_A", alu_in_A, 0);
      chk("rst_alu_in_B", alu_in_B, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_rsp_mode", rsp_mode, 0);
      chk("rst_rsp_err", rsp_err, 0);
      q.delete(); has_cur = 0; got = 0; t = 0; free_at = 0;
    end else begin
      bit e_rv;
      vec++;
      if (!has_cur && q.size() > 0 && t >= (q[0].av > free_at ? q[0].av : free_at)) begin
        cur = q.pop_front(); has_cur = 1; issue = t; got = 0;
      end
      e_rv = has_cur && got && t > rdy_t;
      chk("cmd_ready", cmd_ready, q.size() < DEPTH);
      chk("alu_valid", alu_valid, has_cur && t == issue);
      chk("rsp_valid", rsp_valid, e_rv);
      if (has_cur && t >= issue && !got) begin
        chk("alu_mode", alu_mode, cur.m);
        chk("alu_in_A", alu_in_A, cur.a);
        chk("alu_in_B", alu_in_B, cur.b);
      end
      if (e_rv) begin
        chk("rsp_data", rsp_data, e_data);
        chk("rsp_mode", rsp_mode, cur.m);
        chk("rsp_err", rsp_err, e_err);
      end
      if (alu_valid) nav++;
      if (rsp_valid && rsp_ready) begin
        obs.push_back(rsp_data); obs_mode.push_back(rsp_mode); obs_err.push_back(rsp_err);
      end
      if (cmd_valid && q.size() < DEPTH) q.push_back('{cmd_mode, cmd_a, cmd_b, t + 2});
      if (has_cur && !got && t > issue && alu_ready) begin
        got = 1; rdy_t = t; e_data = alu_f(cur.m, cur.a, cur.b); e_err = 0;
      end
`ifdef ALU_TIMEOUT_EN
      else if (has_cur && !got && t - issue == TO) begin
        got = 1; rdy_t = t; e_data = 0; e_err = 1;
      end
`endif
      if (e_rv && rsp_ready) begin
        has_cur = 0; free_at = t + 2;
      end
      t++;
    end
  end
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic send(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b);
    bit acc = 0;
    cmd_valid = 1; cmd_mode = m; cmd_a = a; cmd_b = b;
    for (int k = 0; k < 400 && !acc; k++) begin
      acc = cmd_ready;
      step(1);
    end
    cmd_valid = 0;
    chk("send_accept", acc, 1);
  endtask
  task automatic wait_rsp(input int n, input int budget);
    for (int k = 0; k < budget && obs.size() < n; k++) step(1);
    chk("rsp_wait", obs.size(), n);
  endtask
  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
  initial begin
    int b, n0;
    rst_n = 0; cmd_valid = 0; cmd_mode = 0; cmd_a = 0; cmd_b = 0; rsp_ready = 1;
    step(3);
    rst_n = 1;
    step(2);
    force_lat = 33;
    send(0, 3, 5);
    wait_rsp(1, 200);
    chk("mulu_data", obs[0], 64'd15);
    chk("mulu_mode", obs_mode[0], 0);
    chk("mulu_pulses", nav, 1);
    step(3);
    force_lat = 30;
    b = obs.size();
    send(0, 7, 7);
    step(8);
    @(posedge clk); #2;
    rst_n = 0;
    step(2);
    rst_n = 1;
    step(50);
    chk("reset_lost", obs.size(), b);
    force_lat = 5;
    rsp_ready = 0;
    n0 = nav;
    b = obs.size();
    for (int i = 0; i < 5; i++) send(0, i + 10, 2);
    step(10);
    chk("bp_full", cmd_ready, 0);
    step(10);
    chk("hold_no_issue", nav - n0, 1);
    chk("hold_data", rsp_data, 64'd20);
    chk("hold_valid", rsp_valid, 1);
    cmd_valid = 1; cmd_mode = 0; cmd_a = 15; cmd_b = 2;
    step(5);
    chk("bp_held", cmd_ready, 0);
    rsp_ready = 1;
    send(0, 15, 2);
    wait_rsp(b + 6, 400);
    for (int i = 0; i < 6; i++)
      if (obs.size() > b + i) chk("bp_order", obs[b + i], 64'((i + 10) * 2));
    force_lat = 2;
    b = obs.size();
    for (int i = 0; i < 20; i++) send(2, 1, i);
    wait_rsp(b + 20, 1000);
    for (int i = 0; i < 20; i++)
      if (obs.size() > b + i) chk("wrap_order", obs[b + i], 64'd1 << i);
`ifdef ALU_TIMEOUT_EN
    force_lat = -1;
    b = obs.size();
    send(1, 100, 7);
    wait_rsp(b + 1, 300);
    if (obs.size() > b) begin
      chk("timeout_err", obs_err[b], 1);
      chk("timeout_data", obs[b], 0);
      chk("timeout_mode", obs_mode[b], 1);
    end
`endif
    force_lat = 0;
    spur_en = 1;
    for (int i = 0; i < 800; i++) begin
      cmd_valid = $urandom_range(0, 2) != 0;
      cmd_mode = 2'($urandom_range(0, 3));
      cmd_a = $urandom;
      cmd_b = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 3)) : $urandom;
      rsp_ready = $urandom_range(0, 3) != 0;
      step(1);
    end
    cmd_valid = 0;
    rsp_ready = 1;
    step(400);
    chk("drain_rsp_valid", rsp_valid, 0);
    chk("drain_cmd_ready", cmd_ready, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
